// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - state encoding, bus widths and byte-lane helpers for the SRAM responder
package sram_pkg;

  localparam int SRAM_DATA_W = 16;
  localparam int SRAM_ADDR_W = 18;

  localparam logic [1:0] LANE_NONE = 2'b00;
  localparam logic [1:0] LANE_LO   = 2'b01;
  localparam logic [1:0] LANE_HI   = 2'b10;
  localparam logic [1:0] LANE_BOTH = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    READ_DRIVE,
    WRITE,
    SCRUB
  } sram_state_t;

  // Active-low lane strobes to an active-high byte-enable mask
  function automatic logic [1:0] lane_mask(input logic ub_n, input logic lb_n);
    return (ub_n ? LANE_NONE : LANE_HI) | (lb_n ? LANE_NONE : LANE_LO);
  endfunction

endpackage

// File: rtl/sram_word_array.sv
// rtl/sram_word_array.sv - word array with a registered byte-lane write port and a combinational read port
module sram_word_array
  import sram_pkg::*;
#(
  parameter int MEM_ADDR_W = 16
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [1:0]             be,
  input  logic [MEM_ADDR_W-1:0]  addr,
  input  logic [SRAM_DATA_W-1:0] wdata,
  input  logic [MEM_ADDR_W-1:0]  raddr,
  output logic [SRAM_DATA_W-1:0] rdata
);

  logic [SRAM_DATA_W-1:0] mem [2**MEM_ADDR_W];

  always_ff @(posedge clk) begin
    if (we && be[0]) mem[addr][7:0]  <= wdata[7:0];
    if (we && be[1]) mem[addr][15:8] <= wdata[15:8];
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - clocked 256K x 16 async SRAM emulation on the SRAM_* pins
// SRAM_SCRUB_EN: zero the whole array after reset before accepting accesses.
module sram_responder
  import sram_pkg::*;
#(
  parameter int ADDR_W       = SRAM_ADDR_W,
  parameter int MEM_ADDR_W   = 16,
  parameter int READ_LATENCY = 2,
  parameter int DATA_W       = SRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  input  logic              SRAM_UB_N,
  input  logic              SRAM_LB_N,
  input  logic              SRAM_CE_N,
  input  logic              SRAM_OE_N,
  input  logic              SRAM_WE_N,
  output logic              model_ready,
  output logic              protocol_err,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  // With a latency of one the first sampled request already completes the wait
  localparam sram_state_t FIRST_RD = (READ_LATENCY == 1) ? READ_DRIVE : READ_WAIT;
`ifdef SRAM_SCRUB_EN
  localparam sram_state_t RESET_STATE = SCRUB;
`else
  localparam sram_state_t RESET_STATE = IDLE;
`endif

  sram_state_t           state, state_nxt;
  logic [ADDR_W-1:0]     lat_addr;
  logic [DATA_W-1:0]     lat_data;
  logic                  lat_ub_n, lat_lb_n;
  logic [3:0]            lat_cnt;
  logic                  sel, rd_req, wr_act, addr_chg, lat_done;
  logic                  rd_start, wr_commit;
  logic                  mem_we;
  logic [1:0]            mem_be;
  logic [MEM_ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata, mem_rdata;
  logic                  drive_lo, drive_hi;
`ifdef SRAM_SCRUB_EN
  logic [MEM_ADDR_W-1:0] scrub_addr;
  logic                  scrub_last;
  assign scrub_last = &scrub_addr;
`endif

  assign sel       = !SRAM_CE_N;
  assign rd_req    = sel && !SRAM_OE_N && SRAM_WE_N;
  assign wr_act    = sel && !SRAM_WE_N;
  assign addr_chg  = SRAM_ADDR != lat_addr;
  assign lat_done  = ({1'b0, lat_cnt} + 5'd1) == 5'(READ_LATENCY);
  assign rd_start  = (state_nxt == READ_DRIVE) && ((state != READ_DRIVE) || addr_chg);
  assign wr_commit = (state == WRITE) && !wr_act;

  always_ff @(posedge clk) begin
    if (reset) state <= RESET_STATE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wr_act)      state_nxt = WRITE;
        else if (rd_req) state_nxt = FIRST_RD;
      end
      READ_WAIT: begin
        if (!rd_req)       state_nxt = IDLE;
        else if (addr_chg) state_nxt = FIRST_RD;
        else if (lat_done) state_nxt = READ_DRIVE;
      end
      READ_DRIVE: begin
        if (!rd_req)       state_nxt = IDLE;
        else if (addr_chg) state_nxt = FIRST_RD;
      end
      WRITE: begin
        if (!wr_act) state_nxt = rd_req ? FIRST_RD : IDLE;
      end
`ifdef SRAM_SCRUB_EN
      SCRUB: begin
        if (scrub_last) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_we      = 1'b0;
    mem_be      = LANE_NONE;
    mem_addr    = lat_addr[MEM_ADDR_W-1:0];
    mem_wdata   = lat_data;
    drive_lo    = 1'b0;
    drive_hi    = 1'b0;
    model_ready = 1'b1;
    case (state)
      READ_DRIVE: begin
        // Output enable and lane strobes act live, like the real chip
        if (rd_req && !addr_chg) begin
          drive_lo = !SRAM_LB_N;
          drive_hi = !SRAM_UB_N;
        end
      end
      WRITE: begin
        if (!wr_act && !reset) begin
          mem_we = 1'b1;
          mem_be = lane_mask(lat_ub_n, lat_lb_n);
        end
      end
`ifdef SRAM_SCRUB_EN
      SCRUB: begin
        model_ready = 1'b0;
        mem_we      = !reset;
        mem_be      = LANE_BOTH;
        mem_addr    = scrub_addr;
        mem_wdata   = '0;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      protocol_err <= 1'b0;
      rd_count     <= 16'd0;
      wr_count     <= 16'd0;
      lat_cnt      <= 4'd1;
`ifdef SRAM_SCRUB_EN
      scrub_addr   <= '0;
`endif
    end else begin
      if (rd_start)  rd_count <= rd_count + 16'd1;
      if (wr_commit) wr_count <= wr_count + 16'd1;
      case (state)
        IDLE: begin
          lat_addr <= SRAM_ADDR;
          lat_cnt  <= 4'd1;
          if (wr_act) begin
            lat_data <= SRAM_DQ;
            lat_ub_n <= SRAM_UB_N;
            lat_lb_n <= SRAM_LB_N;
          end
        end
        READ_WAIT, READ_DRIVE: begin
          if (addr_chg) begin
            lat_addr <= SRAM_ADDR;
            lat_cnt  <= 4'd1;
          end else if (state == READ_WAIT) begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        WRITE: begin
          lat_addr <= SRAM_ADDR;
          lat_cnt  <= 4'd1;
          if (wr_act) begin
            // Moving the address under a held write abandons the old word
            if (addr_chg) protocol_err <= 1'b1;
            lat_data <= SRAM_DQ;
            lat_ub_n <= SRAM_UB_N;
            lat_lb_n <= SRAM_LB_N;
          end
        end
`ifdef SRAM_SCRUB_EN
        SCRUB: begin
          scrub_addr <= scrub_addr + 1'b1;
          if (sel) protocol_err <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  sram_word_array #(.MEM_ADDR_W(MEM_ADDR_W)) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (mem_be),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .raddr (lat_addr[MEM_ADDR_W-1:0]),
    .rdata (mem_rdata)
  );

  assign SRAM_DQ[7:0]  = drive_lo ? mem_rdata[7:0]  : 8'bz;
  assign SRAM_DQ[15:8] = drive_hi ? mem_rdata[15:8] : 8'bz;

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - randomized self-checking bench for sram_responder against a word-map model
`timescale 1ns/1ps
module tb_sram_responder;

  localparam int RL = 2;
`ifdef SRAM_SCRUB_EN
  localparam int MAW = 4;
`else
  localparam int MAW = 16;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [17:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic        SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N, SRAM_WE_N;
  logic        model_ready, protocol_err;
  logic [15:0] rd_count, wr_count;
  logic [15:0] dq_drv;
  logic        dq_oe;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_rd, exp_wr;
  logic [15:0] ref_mem [int];

  // Undriven bus bits read as 0 through the pulldowns
  assign SRAM_DQ = dq_oe ? dq_drv : 16'bz;
  for (genvar i = 0; i < 16; i++) begin : g_pd
    pulldown (SRAM_DQ[i]);
  end

  always #5 clk = ~clk;

  sram_responder #(.ADDR_W(18), .MEM_ADDR_W(MAW), .READ_LATENCY(RL), .DATA_W(16)) dut (
    .clk(clk), .reset(reset), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ),
    .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N), .SRAM_CE_N(SRAM_CE_N),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N), .model_ready(model_ready),
    .protocol_err(protocol_err), .rd_count(rd_count), .wr_count(wr_count)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle;
    SRAM_CE_N = 1'b1; SRAM_OE_N = 1'b1; SRAM_WE_N = 1'b1;
    SRAM_UB_N = 1'b0; SRAM_LB_N = 1'b0; dq_oe = 1'b0;
  endtask

  function automatic int key(input logic [17:0] a);
    return int'(a[MAW-1:0]);
  endfunction

  function automatic logic [15:0] model_read(input logic [17:0] a, input logic ub_n, input logic lb_n);
    logic [15:0] w;
    w = ref_mem.exists(key(a)) ? ref_mem[key(a)] : 16'h0000;
    return {ub_n ? 8'h00 : w[15:8], lb_n ? 8'h00 : w[7:0]};
  endfunction

  task automatic model_write(input logic [17:0] a, input logic [15:0] d, input logic ub_n, input logic lb_n);
    logic [15:0] w;
    w = ref_mem.exists(key(a)) ? ref_mem[key(a)] : 16'h0000;
    if (!lb_n) w[7:0]  = d[7:0];
    if (!ub_n) w[15:8] = d[15:8];
    ref_mem[key(a)] = w;
    exp_wr = exp_wr + 16'd1;
  endtask

  task automatic do_write(input logic [17:0] a, input logic [15:0] d, input logic ub_n, input logic lb_n, input int ncyc);
    SRAM_ADDR = a; dq_drv = d; dq_oe = 1'b1;
    SRAM_UB_N = ub_n; SRAM_LB_N = lb_n; SRAM_CE_N = 1'b0; SRAM_WE_N = 1'b0;
    repeat (ncyc) tick;
    bus_idle;
    tick;
    model_write(a, d, ub_n, lb_n);
  endtask

  task automatic do_read(input logic [17:0] a, input logic ub_n, input logic lb_n, output logic [15:0] q);
    SRAM_ADDR = a; SRAM_UB_N = ub_n; SRAM_LB_N = lb_n;
    SRAM_CE_N = 1'b0; SRAM_OE_N = 1'b0;
    repeat (RL) tick;
    q = SRAM_DQ;
    bus_idle;
    tick;
    exp_rd = exp_rd + 16'd1;
  endtask

  task automatic release_reset;
    int n;
    reset = 1'b0;
    exp_rd = 16'd0;
    exp_wr = 16'd0;
`ifdef SRAM_SCRUB_EN
    n = 0;
    while (model_ready !== 1'b1 && n < (1 << MAW) + 8) begin
      tick;
      n++;
    end
    total++;
    if (model_ready !== 1'b1) begin
      bad++;
      $display("FAIL scrub_ready_timeout: model_ready=%b after %0d cycles, required 1", model_ready, n);
    end
    for (int k = 0; k < (1 << MAW); k++) ref_mem[k] = 16'h0000;
`else
    n = 0;
`endif
  endtask

  task automatic do_reset;
    reset = 1'b1;
    bus_idle;
    tick;
    tick;
    release_reset;
  endtask

  task automatic test_reset;
    int n;
    reset = 1'b1;
    bus_idle;
    SRAM_ADDR = '0;
    dq_drv = '0;
    tick;
    tick;
    total++; if (rd_count !== 16'd0) begin bad++; $display("FAIL reset_rd_count: got %h want 0000", rd_count); end
    total++; if (wr_count !== 16'd0) begin bad++; $display("FAIL reset_wr_count: got %h want 0000", wr_count); end
    total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", protocol_err); end
    total++; if (SRAM_DQ !== 16'h0000) begin bad++; $display("FAIL reset_dq_undriven: got %h want 0000", SRAM_DQ); end
`ifdef SRAM_SCRUB_EN
    total++; if (model_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", model_ready); end
    reset = 1'b0;
    n = 0;
    while (model_ready !== 1'b1 && n < (1 << MAW) + 8) begin
      tick;
      n++;
    end
    total++; if (n != (1 << MAW)) begin bad++; $display("FAIL scrub_sweep_len: got %0d want %0d", n, 1 << MAW); end
    for (int k = 0; k < (1 << MAW); k++) ref_mem[k] = 16'h0000;
`else
    total++; if (model_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", model_ready); end
    reset = 1'b0;
    n = 0;
`endif
    exp_rd = 16'd0;
    exp_wr = 16'd0;
  endtask

  task automatic test_write_read_latency;
    do_write(18'h00010, 16'hA5C3, 1'b0, 1'b0, 2);
    SRAM_ADDR = 18'h00010; SRAM_CE_N = 1'b0; SRAM_OE_N = 1'b0;
    repeat (RL - 1) tick;
    total++; if (SRAM_DQ !== 16'h0000) begin bad++; $display("FAIL lat_early: got %h want 0000", SRAM_DQ); end
    tick;
    total++; if (SRAM_DQ !== 16'hA5C3) begin bad++; $display("FAIL lat_data: got %h want a5c3", SRAM_DQ); end
    bus_idle;
    tick;
    exp_rd = exp_rd + 16'd1;
    total++; if (wr_count !== exp_wr) begin bad++; $display("FAIL basic_wr_count: got %0d want %0d", wr_count, exp_wr); end
    total++; if (rd_count !== exp_rd) begin bad++; $display("FAIL basic_rd_count: got %0d want %0d", rd_count, exp_rd); end
  endtask

  task automatic test_byte_lanes;
    logic [15:0] q;
    do_write(18'd5, 16'hFFFF, 1'b0, 1'b0, 1);
    do_write(18'd5, 16'h1234, 1'b1, 1'b0, 2);
    do_read(18'd5, 1'b0, 1'b0, q);
    total++; if (q !== model_read(18'd5, 1'b0, 1'b0)) begin bad++; $display("FAIL lane_lb_write: got %h want %h", q, model_read(18'd5, 1'b0, 1'b0)); end
    do_read(18'd5, 1'b1, 1'b0, q);
    total++; if (q !== model_read(18'd5, 1'b1, 1'b0)) begin bad++; $display("FAIL lane_ub_off_read: got %h want %h", q, model_read(18'd5, 1'b1, 1'b0)); end
  endtask

  task automatic test_we_over_oe;
    logic [15:0] q;
    do_write(18'd7, 16'h5555, 1'b0, 1'b0, 1);
    SRAM_ADDR = 18'd7; dq_drv = 16'h0BAD; dq_oe = 1'b1;
    SRAM_CE_N = 1'b0; SRAM_WE_N = 1'b0; SRAM_OE_N = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick;
      total++; if (SRAM_DQ !== 16'h0BAD) begin bad++; $display("FAIL we_oe_bus: cycle %0d got %h want 0bad", c, SRAM_DQ); end
    end
    bus_idle;
    tick;
    model_write(18'd7, 16'h0BAD, 1'b0, 1'b0);
    do_read(18'd7, 1'b0, 1'b0, q);
    total++; if (q !== model_read(18'd7, 1'b0, 1'b0)) begin bad++; $display("FAIL we_oe_readback: got %h want %h", q, model_read(18'd7, 1'b0, 1'b0)); end
    total++; if (rd_count !== exp_rd) begin bad++; $display("FAIL we_oe_rd_count: got %0d want %0d", rd_count, exp_rd); end
  endtask

  task automatic test_addr_change;
    logic [15:0] q;
    do_write(18'd3, 16'h3333, 1'b0, 1'b0, 1);
    do_write(18'd4, 16'h4444, 1'b0, 1'b0, 1);
    SRAM_ADDR = 18'd3; dq_drv = 16'hC0DE; dq_oe = 1'b1;
    SRAM_CE_N = 1'b0; SRAM_WE_N = 1'b0;
    tick;
    SRAM_ADDR = 18'd4;
    tick;
    total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL addr_chg_err: got %b want 1", protocol_err); end
    total++; if (wr_count !== exp_wr) begin bad++; $display("FAIL addr_chg_hold_cnt: got %0d want %0d", wr_count, exp_wr); end
    tick;
    total++; if (wr_count !== exp_wr) begin bad++; $display("FAIL addr_chg_hold_cnt2: got %0d want %0d", wr_count, exp_wr); end
    bus_idle;
    tick;
    model_write(18'd4, 16'hC0DE, 1'b0, 1'b0);
    total++; if (wr_count !== exp_wr) begin bad++; $display("FAIL addr_chg_commit_cnt: got %0d want %0d", wr_count, exp_wr); end
    do_read(18'd4, 1'b0, 1'b0, q);
    total++; if (q !== model_read(18'd4, 1'b0, 1'b0)) begin bad++; $display("FAIL addr_chg_new: got %h want %h", q, model_read(18'd4, 1'b0, 1'b0)); end
    do_read(18'd3, 1'b0, 1'b0, q);
    total++; if (q !== model_read(18'd3, 1'b0, 1'b0)) begin bad++; $display("FAIL addr_chg_old: got %h want %h", q, model_read(18'd3, 1'b0, 1'b0)); end
    total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", protocol_err); end
  endtask

  task automatic test_reset_abort;
    logic [15:0] q;
    do_reset;
    total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL err_cleared: got %b want 0", protocol_err); end
    do_write(18'd9, 16'h9A9A, 1'b0, 1'b0, 1);
    SRAM_ADDR = 18'd9; SRAM_CE_N = 1'b0; SRAM_OE_N = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    total++; if (SRAM_DQ !== 16'h0000) begin bad++; $display("FAIL abort_rd_dq: got %h want 0000", SRAM_DQ); end
    total++; if (rd_count !== 16'd0) begin bad++; $display("FAIL abort_rd_count: got %0d want 0", rd_count); end
    bus_idle;
    tick;
    release_reset;
    SRAM_ADDR = 18'd9; dq_drv = 16'h1111; dq_oe = 1'b1;
    SRAM_CE_N = 1'b0; SRAM_WE_N = 1'b0;
    tick;
    reset = 1'b1;
    bus_idle;
    tick;
    total++; if (wr_count !== 16'd0) begin bad++; $display("FAIL abort_wr_count: got %0d want 0", wr_count); end
    release_reset;
    do_read(18'd9, 1'b0, 1'b0, q);
    total++; if (q !== model_read(18'd9, 1'b0, 1'b0)) begin bad++; $display("FAIL abort_mem_intact: got %h want %h", q, model_read(18'd9, 1'b0, 1'b0)); end
    total++; if (rd_count !== exp_rd) begin bad++; $display("FAIL abort_rd_after: got %0d want %0d", rd_count, exp_rd); end
  endtask

  task automatic test_random;
    logic [17:0] a;
    logic [15:0] q, d, e;
    logic        ub, lb;
    int          lows [6] = '{1, 2, 6, 8, 11, 13};
    bit          known [6];
    int          idx;
    for (int i = 0; i < 6; i++) known[i] = 1'b0;
    for (int it = 0; it < 40; it++) begin
      idx = $urandom_range(0, 5);
      a = 18'($urandom);
      a[MAW-1:0] = '0;
      a = a | 18'(lows[idx]);
      ub = 1'($urandom);
      lb = 1'($urandom);
      if (!known[idx] || $urandom_range(0, 1) == 0) begin
        d = 16'($urandom);
        if (!known[idx]) begin ub = 1'b0; lb = 1'b0; end
        do_write(a, d, ub, lb, $urandom_range(1, 3));
        known[idx] = 1'b1;
      end else begin
        e = model_read(a, ub, lb);
        do_read(a, ub, lb, q);
        total++; if (q !== e) begin bad++; $display("FAIL rand_read: it %0d addr %h lanes ub_n=%b lb_n=%b got %h want %h", it, a, ub, lb, q, e); end
      end
    end
    total++; if (wr_count !== exp_wr) begin bad++; $display("FAIL rand_wr_count: got %0d want %0d", wr_count, exp_wr); end
    total++; if (rd_count !== exp_rd) begin bad++; $display("FAIL rand_rd_count: got %0d want %0d", rd_count, exp_rd); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] d12, d14;
    d12 = 16'($urandom) | 16'h0101;
    d14 = 16'($urandom) | 16'h1010;
    do_write(18'd14, d14, 1'b0, 1'b0, 1);
    SRAM_ADDR = 18'd12; dq_drv = d12; dq_oe = 1'b1;
    SRAM_CE_N = 1'b0; SRAM_WE_N = 1'b0;
    tick;
    SRAM_WE_N = 1'b1; dq_oe = 1'b0; SRAM_OE_N = 1'b0;
    model_write(18'd12, d12, 1'b0, 1'b0);
    repeat (RL) tick;
    total++; if (SRAM_DQ !== model_read(18'd12, 1'b0, 1'b0)) begin bad++; $display("FAIL b2b_raw: got %h want %h", SRAM_DQ, model_read(18'd12, 1'b0, 1'b0)); end
    SRAM_ADDR = 18'd14;
    repeat (RL) tick;
    total++; if (SRAM_DQ !== model_read(18'd14, 1'b0, 1'b0)) begin bad++; $display("FAIL b2b_addr_move: got %h want %h", SRAM_DQ, model_read(18'd14, 1'b0, 1'b0)); end
    bus_idle;
    tick;
    exp_rd = exp_rd + 16'd2;
    total++; if (rd_count !== exp_rd) begin bad++; $display("FAIL b2b_rd_count: got %0d want %0d", rd_count, exp_rd); end
    total++; if (wr_count !== exp_wr) begin bad++; $display("FAIL b2b_wr_count: got %0d want %0d", wr_count, exp_wr); end
  endtask

`ifdef SRAM_SCRUB_EN
  task automatic test_scrub;
    logic [15:0] q;
    int n;
    do_write(18'd15, 16'hBEEF, 1'b0, 1'b0, 1);
    reset = 1'b1;
    bus_idle;
    tick;
    tick;
    reset = 1'b0;
    n = 0;
    tick; n++;
    tick; n++;
    SRAM_CE_N = 1'b0;
    tick; n++;
    SRAM_CE_N = 1'b1;
    while (model_ready !== 1'b1 && n < (1 << MAW) + 8) begin
      tick;
      n++;
    end
    total++; if (n != (1 << MAW)) begin bad++; $display("FAIL scrub_len2: got %0d want %0d", n, 1 << MAW); end
    total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL scrub_strobe_err: got %b want 1", protocol_err); end
    for (int k = 0; k < (1 << MAW); k++) ref_mem[k] = 16'h0000;
    exp_rd = 16'd0;
    exp_wr = 16'd0;
    do_read(18'd15, 1'b0, 1'b0, q);
    total++; if (q !== model_read(18'd15, 1'b0, 1'b0)) begin bad++; $display("FAIL scrub_zero: got %h want %h", q, model_read(18'd15, 1'b0, 1'b0)); end
    total++; if (rd_count !== exp_rd) begin bad++; $display("FAIL scrub_rd_count: got %0d want %0d", rd_count, exp_rd); end
  endtask
`endif

  initial begin
    exp_rd = 16'd0;
    exp_wr = 16'd0;
    test_reset;
    test_write_read_latency;
    test_byte_lanes;
    test_we_over_oe;
    test_addr_change;
    test_reset_abort;
    test_random;
    test_back_to_back;
`ifdef SRAM_SCRUB_EN
    test_scrub;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
